// File: rtl/pixel_readout_if.sv
// rtl/pixel_readout_if.sv - pixel readout stream: code, index and saturation flag with valid/ready
interface pixel_readout_if #(
    parameter int N_PIXELS = 4,
    parameter int DATA_W   = 8
);
    localparam int IDX_W = $clog2(N_PIXELS);

    logic [DATA_W-1:0] pixel_data;
    logic [IDX_W-1:0]  pixel_index;
    logic              pixel_sat;
    logic              pixel_valid;
    logic              pixel_ready;

    modport master (
        output pixel_data,
        output pixel_index,
        output pixel_sat,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_index,
        input  pixel_sat,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

// File: rtl/pixel_readout.sv
// rtl/pixel_readout.sv - single-slope column ADC capture of ramp codes and in-order pixel readout
module pixel_readout #(
    parameter int N_PIXELS = 4,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                conv_start,
    input  logic [DATA_W-1:0]   ramp_code,
    input  logic [N_PIXELS-1:0] comp,
    input  logic                adc_finished,
    pixel_readout_if.master     pix,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);
    localparam int                IDX_W      = $clog2(N_PIXELS);
    localparam logic [DATA_W-1:0] FULL_SCALE = {DATA_W{1'b1}};
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, READOUT, DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   code_q [N_PIXELS];
    logic [DATA_W-1:0]   code_d [N_PIXELS];
    logic [N_PIXELS-1:0] latched_q, latched_d;
    logic [N_PIXELS-1:0] sat_q, sat_d;
    logic                overrun_q, overrun_d;
    logic                valid;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        code_d     = code_q;
        latched_d  = latched_q;
        sat_d      = sat_q;
        overrun_d  = overrun_q;
        valid      = 1'b0;
        frame_done = 1'b0;

        // A start request that cannot be honoured is only recorded, never acted on.
        if (conv_start && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (conv_start) begin
                    for (int i = 0; i < N_PIXELS; i++) begin
                        code_d[i] = '0;
                    end
                    latched_d = '0;
                    sat_d     = '0;
                    overrun_d = 1'b0;
                    idx_d     = '0;
                    state_d   = CONVERT;
                end
            end

            CONVERT: begin
                for (int i = 0; i < N_PIXELS; i++) begin
                    if (comp[i] && !latched_q[i]) begin
                        code_d[i]    = ramp_code;
                        latched_d[i] = 1'b1;
                    end
                end
                // Same-cycle crossings are captured first; only the remainder saturate.
                if (adc_finished) begin
                    for (int i = 0; i < N_PIXELS; i++) begin
                        if (!latched_d[i]) begin
                            code_d[i]    = FULL_SCALE;
                            sat_d[i]     = 1'b1;
                            latched_d[i] = 1'b1;
                        end
                    end
                    idx_d   = '0;
                    state_d = READOUT;
                end
            end

            READOUT: begin
                valid = 1'b1;
                if (pix.pixel_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            DONE: begin
                frame_done = 1'b1;
                idx_d      = '0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            latched_q <= '0;
            sat_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_PIXELS; i++) begin
                code_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            latched_q <= latched_d;
            sat_q     <= sat_d;
            overrun_q <= overrun_d;
            code_q    <= code_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign overrun         = overrun_q;
    assign pix.pixel_valid = valid;
    assign pix.pixel_index = idx_q;
    assign pix.pixel_data  = code_q[idx_q];
    assign pix.pixel_sat   = sat_q[idx_q];
endmodule
